// File: rtl/spi_slave_cmd_if.sv
// -----------------------------------------------------------------------------
// spi_slave_cmd_if
//
// Bundle of every signal that crosses the spi_slave_cmd boundary except the
// clock and reset: the four SPI pins plus the access port of the 16x8
// register memory that the front end drives.
//
// Modports
//   slave  : view taken by spi_slave_cmd (SPI pins and buffer_tx in,
//            MISO and memory strobes out)
//   master : view taken by whatever plays SPI master and memory
//            (SPI pins and buffer_tx out, MISO and strobes in)
//
// Signals
//   sck, cs_n, mosi : SPI mode 0 pins, asynchronous to mem_clk
//   miso, miso_oe   : SPI data out and its drive enable
//   mem_en          : high while a transaction is active
//   mem_address     : memory address (ADDR_W bits)
//   buffer_rx       : write data to memory (DATA_W bits)
//   buffer_tx       : read data from memory, valid one cycle after mem_re
//   mem_we, mem_re, mem_initial : single-cycle write / read / clear strobes
// -----------------------------------------------------------------------------
interface spi_slave_cmd_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              sck;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] buffer_rx;
    logic [DATA_W-1:0] buffer_tx;
    logic              mem_we;
    logic              mem_re;
    logic              mem_initial;

    modport slave (
        input  sck, cs_n, mosi, buffer_tx,
        output miso, miso_oe, mem_en, mem_address, buffer_rx,
               mem_we, mem_re, mem_initial
    );

    modport master (
        output sck, cs_n, mosi, buffer_tx,
        input  miso, miso_oe, mem_en, mem_address, buffer_rx,
               mem_we, mem_re, mem_initial
    );
endinterface

// File: rtl/spi_slave_cmd.sv
// -----------------------------------------------------------------------------
// spi_slave_cmd
//
// SPI mode-0 slave front end for the 16x8 register memory. SCK, CS_N and MOSI
// are oversampled on mem_clk; the first byte of each transaction is a command
// that is decoded into single-cycle write, read or clear strobes towards the
// memory. Read data returned on buffer_tx is shifted back out on MISO.
//
// Command byte
//   1xxx_aaaa : WRITE, next byte is written to address aaaa
//   0000_aaaa : READ, data of address aaaa is returned in the next byte
//   0100_0000 : CLEAR the whole memory
//   anything else is reserved and ignored (e.g. 0x20 is not a read)
//
// Ports
//   mem_clk   : system clock shared with the memory (>= 8x SCK)
//   mem_rst_n : asynchronous active-low reset
//   bus       : spi_slave_cmd_if.slave (SPI pins and memory access port)
//
// Optional feature (macro SPI_BURST_EN)
//   Defined   : write and read data phases continue byte after byte, with
//               the address incrementing modulo 2^ADDR_W for each byte.
//   Undefined : only the first data byte is used; later bytes are ignored.
// -----------------------------------------------------------------------------
module spi_slave_cmd #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 mem_clk,
    input  logic                 mem_rst_n,
    spi_slave_cmd_if.slave       bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_IGNORE  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_CLEAR = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    localparam logic [DATA_W-1:0] CLEAR_CODE = 8'h40;
`ifdef SPI_BURST_EN
    localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
`endif

    // Command decode; READ requires every non-address bit to be zero.
    function automatic op_e decode_op(input logic [DATA_W-1:0] cmd);
        op_e op;
        if (cmd[DATA_W-1]) begin
            op = OP_WRITE;
        end else if (cmd[DATA_W-1:ADDR_W] == {(DATA_W-ADDR_W){1'b0}}) begin
            op = OP_READ;
        end else if (cmd == CLEAR_CODE) begin
            op = OP_CLEAR;
        end else begin
            op = OP_RSVD;
        end
        return op;
    endfunction

    // Synchroniser chains and one-cycle-delayed copies for edge detection
    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sck_prev_r;
    logic                   cs_prev_r;

    logic sck_s, cs_s, mosi_s;
    logic sck_rise_s, sck_fall_s, cs_rise_s, cs_fall_s;

    // FSM and datapath state
    state_e            state_r, state_nxt_s;
    logic [2:0]        bit_cnt_r, bit_cnt_nxt_s;
    logic [DATA_W-1:0] shift_r, shift_nxt_s;
    logic [DATA_W-1:0] tx_r, tx_nxt_s;
    logic [ADDR_W-1:0] addr_r, addr_nxt_s;
    logic [DATA_W-1:0] rx_r, rx_nxt_s;
    logic              miso_r, miso_nxt_s;
    logic              miso_oe_r, miso_oe_nxt_s;
    logic              mem_en_r, mem_en_nxt_s;
    logic              we_r, we_nxt_s;
    logic              re_r, re_nxt_s;
    logic              init_r, init_nxt_s;
`ifdef SPI_BURST_EN
    logic              wr_more_r, wr_more_nxt_s;
`endif

    logic [DATA_W-1:0] rx_byte_s;
    logic              byte_done_s;

    // Input synchronisers. The cs_n chain resets low so that a cs_n already
    // low when reset is released does not look like a fresh falling edge.
    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            sck_sync_r  <= {SYNC_STAGES{1'b0}};
            cs_sync_r   <= {SYNC_STAGES{1'b0}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            sck_prev_r  <= 1'b0;
            cs_prev_r   <= 1'b0;
        end else begin
            sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], bus.sck};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], bus.cs_n};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], bus.mosi};
            sck_prev_r  <= sck_sync_r[SYNC_STAGES-1];
            cs_prev_r   <= cs_sync_r[SYNC_STAGES-1];
        end
    end

    // Edge detection on the synchronised pins
    always_comb begin
        sck_s       = sck_sync_r[SYNC_STAGES-1];
        cs_s        = cs_sync_r[SYNC_STAGES-1];
        mosi_s      = mosi_sync_r[SYNC_STAGES-1];
        sck_rise_s  = sck_s & ~sck_prev_r;
        sck_fall_s  = ~sck_s & sck_prev_r;
        cs_rise_s   = cs_s & ~cs_prev_r;
        cs_fall_s   = ~cs_s & cs_prev_r;
        rx_byte_s   = {shift_r[DATA_W-2:0], mosi_s};
        byte_done_s = sck_rise_s & (bit_cnt_r == 3'd7);
    end

    // FSM state register
    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        shift_nxt_s   = shift_r;
        tx_nxt_s      = tx_r;
        addr_nxt_s    = addr_r;
        rx_nxt_s      = rx_r;
        miso_nxt_s    = miso_r;
        miso_oe_nxt_s = miso_oe_r;
        mem_en_nxt_s  = mem_en_r;
        we_nxt_s      = 1'b0;
        re_nxt_s      = 1'b0;
        init_nxt_s    = 1'b0;
`ifdef SPI_BURST_EN
        wr_more_nxt_s = wr_more_r;
`endif
        if (cs_rise_s) begin
            // End of transaction wins over everything; a partial byte
            // never produces a strobe.
            state_nxt_s   = ST_IDLE;
            bit_cnt_nxt_s = 3'd0;
            miso_nxt_s    = 1'b0;
            miso_oe_nxt_s = 1'b0;
            mem_en_nxt_s  = 1'b0;
        end else begin
            if ((state_r != ST_IDLE) && sck_rise_s) begin
                bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                shift_nxt_s   = rx_byte_s;
            end else begin
                shift_nxt_s   = shift_r;
            end

            case (state_r)
                ST_IDLE: begin
                    miso_nxt_s = 1'b0;
                    if (cs_fall_s) begin
                        state_nxt_s   = ST_CMD;
                        bit_cnt_nxt_s = 3'd0;
                        mem_en_nxt_s  = 1'b1;
                        miso_oe_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s   = ST_IDLE;
                    end
                end

                ST_CMD: begin
                    miso_nxt_s = 1'b0;
                    if (byte_done_s) begin
                        addr_nxt_s = rx_byte_s[ADDR_W-1:0];
                        case (decode_op(rx_byte_s))
                            OP_WRITE: begin
                                state_nxt_s   = ST_WR_DATA;
`ifdef SPI_BURST_EN
                                wr_more_nxt_s = 1'b0;
`endif
                            end
                            OP_READ: begin
                                re_nxt_s    = 1'b1;
                                state_nxt_s = ST_RD_WAIT;
                            end
                            OP_CLEAR: begin
                                init_nxt_s  = 1'b1;
                                state_nxt_s = ST_IGNORE;
                            end
                            default: begin
                                state_nxt_s = ST_IGNORE;
                            end
                        endcase
                    end else begin
                        state_nxt_s = ST_CMD;
                    end
                end

                ST_RD_WAIT: begin
                    // While mem_re is still high the memory has not yet
                    // produced buffer_tx; load on the following cycle.
                    if (!re_r) begin
                        tx_nxt_s    = bus.buffer_tx;
                        miso_nxt_s  = bus.buffer_tx[DATA_W-1];
                        state_nxt_s = ST_RD_DATA;
                    end else begin
                        state_nxt_s = ST_RD_WAIT;
                    end
                end

                ST_RD_DATA: begin
                    // The fall that closes the previous byte keeps the MSB
                    // on the line; later falls advance one bit each.
                    if (sck_fall_s) begin
                        if (bit_cnt_r == 3'd0) begin
                            miso_nxt_s = tx_r[DATA_W-1];
                        end else begin
                            tx_nxt_s   = {tx_r[DATA_W-2:0], 1'b0};
                            miso_nxt_s = tx_r[DATA_W-2];
                        end
                    end else begin
                        miso_nxt_s = miso_r;
                    end
                    if (byte_done_s) begin
`ifdef SPI_BURST_EN
                        addr_nxt_s  = addr_r + ADDR_ONE;
                        re_nxt_s    = 1'b1;
                        state_nxt_s = ST_RD_WAIT;
`else
                        miso_nxt_s  = 1'b0;
                        state_nxt_s = ST_IGNORE;
`endif
                    end else begin
                        state_nxt_s = ST_RD_DATA;
                    end
                end

                ST_WR_DATA: begin
                    miso_nxt_s = 1'b0;
                    if (byte_done_s) begin
                        rx_nxt_s = rx_byte_s;
                        we_nxt_s = 1'b1;
`ifdef SPI_BURST_EN
                        // First data byte goes to the command address;
                        // each later byte moves the address along with it.
                        if (wr_more_r) begin
                            addr_nxt_s = addr_r + ADDR_ONE;
                        end else begin
                            addr_nxt_s = addr_r;
                        end
                        wr_more_nxt_s = 1'b1;
                        state_nxt_s   = ST_WR_DATA;
`else
                        state_nxt_s   = ST_IGNORE;
`endif
                    end else begin
                        state_nxt_s = ST_WR_DATA;
                    end
                end

                ST_IGNORE: begin
                    miso_nxt_s  = 1'b0;
                    state_nxt_s = ST_IGNORE;
                end

                default: begin
                    state_nxt_s   = ST_IDLE;
                    bit_cnt_nxt_s = 3'd0;
                    miso_nxt_s    = 1'b0;
                    miso_oe_nxt_s = 1'b0;
                    mem_en_nxt_s  = 1'b0;
                end
            endcase
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            bit_cnt_r <= 3'd0;
            shift_r   <= {DATA_W{1'b0}};
            tx_r      <= {DATA_W{1'b0}};
            addr_r    <= {ADDR_W{1'b0}};
            rx_r      <= {DATA_W{1'b0}};
            miso_r    <= 1'b0;
            miso_oe_r <= 1'b0;
            mem_en_r  <= 1'b0;
            we_r      <= 1'b0;
            re_r      <= 1'b0;
            init_r    <= 1'b0;
`ifdef SPI_BURST_EN
            wr_more_r <= 1'b0;
`endif
        end else begin
            bit_cnt_r <= bit_cnt_nxt_s;
            shift_r   <= shift_nxt_s;
            tx_r      <= tx_nxt_s;
            addr_r    <= addr_nxt_s;
            rx_r      <= rx_nxt_s;
            miso_r    <= miso_nxt_s;
            miso_oe_r <= miso_oe_nxt_s;
            mem_en_r  <= mem_en_nxt_s;
            we_r      <= we_nxt_s;
            re_r      <= re_nxt_s;
            init_r    <= init_nxt_s;
`ifdef SPI_BURST_EN
            wr_more_r <= wr_more_nxt_s;
`endif
        end
    end

    assign bus.miso        = miso_r;
    assign bus.miso_oe     = miso_oe_r;
    assign bus.mem_en      = mem_en_r;
    assign bus.mem_address = addr_r;
    assign bus.buffer_rx   = rx_r;
    assign bus.mem_we      = we_r;
    assign bus.mem_re      = re_r;
    assign bus.mem_initial = init_r;

endmodule

// File: tb/tb_spi_slave_cmd.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_cmd
//
// Drives spi_slave_cmd as an SPI mode-0 master (SCK half period = 8 mem_clk
// cycles) and models the 16x8 memory behind it. Every strobe the DUT issues
// is recorded; expected strobes are queued before each transaction and
// compared in order once the transaction is over.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_slave_cmd;

    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    logic [7:0]  mem [16];

    spi_slave_cmd_if bus ();

    spi_slave_cmd dut (
        .mem_clk   (clk),
        .mem_rst_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Memory model: read data appears one cycle after mem_re
    always @(posedge clk) begin
        if (bus.mem_initial) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
        end else if (bus.mem_we) begin
            mem[bus.mem_address] <= bus.buffer_rx;
        end
        if (bus.mem_re) bus.buffer_tx <= mem[bus.mem_address];
    end

    // Strobe recorder: one entry per cycle in which any strobe is high
    always @(negedge clk) begin
        if (bus.mem_we | bus.mem_re | bus.mem_initial)
            obs_q.push_back({17'd0, bus.mem_we, bus.mem_re, bus.mem_initial,
                             bus.mem_address, (bus.mem_we ? bus.buffer_rx : 8'h00)});
    end

    function automatic logic [31:0] ev_we(input logic [3:0] a, input logic [7:0] d);
        return {17'd0, 3'b100, a, d};
    endfunction
    function automatic logic [31:0] ev_re(input logic [3:0] a);
        return {17'd0, 3'b010, a, 8'h00};
    endfunction
    function automatic logic [31:0] ev_init(input logic [3:0] a);
        return {17'd0, 3'b001, a, 8'h00};
    endfunction

    function automatic logic [31:0] out_vec();
        return {14'd0, bus.miso, bus.miso_oe, bus.mem_en, bus.mem_address,
                bus.buffer_rx, bus.mem_we, bus.mem_re, bus.mem_initial};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_events(input string tag);
        check({tag, " strobe count"}, obs_q.size(), exp_q.size());
        while ((exp_q.size() > 0) && (obs_q.size() > 0))
            check({tag, " strobe"}, obs_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        obs_q.delete();
    endtask

    // Shift the top nb bits of tx out MSB first; MISO sampled on each rise
    task automatic send_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nb; i--) begin
            bus.mosi = tx[i];
            repeat (HALF) @(posedge clk);
            bus.sck = 1'b1;
            rx[i] = bus.miso;
            repeat (HALF) @(posedge clk);
            bus.sck = 1'b0;
        end
    endtask

    task automatic xfer(input string tag, input int n,
                        input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2,
                        output logic [7:0] r0, output logic [7:0] r1, output logic [7:0] r2);
        r1 = 8'h00;
        r2 = 8'h00;
        bus.cs_n = 1'b0;
        repeat (HALF) @(posedge clk);
        check({tag, " active en/oe"}, {30'd0, bus.mem_en, bus.miso_oe}, 32'd3);
        send_bits(t0, 8, r0);
        if (n > 1) send_bits(t1, 8, r1);
        if (n > 2) send_bits(t2, 8, r2);
        repeat (HALF) @(posedge clk);
        bus.cs_n = 1'b1;
        repeat (HALF) @(posedge clk);
        check({tag, " idle en/oe"}, {30'd0, bus.mem_en, bus.miso_oe}, 32'd0);
        check_events(tag);
    endtask

    initial begin
        logic [7:0] r0, r1, r2;
        rst_n    = 1'b0;
        bus.sck  = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", out_vec(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        check("idle outputs", out_vec(), 32'd0);

        // Plain write
        exp_q.push_back(ev_we(4'd3, 8'hA5));
        xfer("wr 83 A5", 2, 8'h83, 8'hA5, 8'h00, r0, r1, r2);
        check("wr buffer_rx held", {24'd0, bus.buffer_rx}, 32'h0000_00A5);

        // Write then read back through MISO
        exp_q.push_back(ev_we(4'd10, 8'h5A));
        xfer("wr 8A 5A", 2, 8'h8A, 8'h5A, 8'h00, r0, r1, r2);
        exp_q.push_back(ev_re(4'd10));
        xfer("rd 0A", 2, 8'h0A, 8'h00, 8'h00, r0, r1, r2);
        check("rd 0A miso cmd", {24'd0, r0}, 32'h0000_0000);
        check("rd 0A miso data", {24'd0, r1}, 32'h0000_005A);

        // Clear wipes previously written data
        exp_q.push_back(ev_we(4'd15, 8'h77));
        xfer("wr 8F 77", 2, 8'h8F, 8'h77, 8'h00, r0, r1, r2);
        exp_q.push_back(ev_init(4'd0));
        xfer("clear 40", 1, 8'h40, 8'h00, 8'h00, r0, r1, r2);
        exp_q.push_back(ev_re(4'd15));
        xfer("rd 0F", 2, 8'h0F, 8'h00, 8'h00, r0, r1, r2);
        check("rd 0F after clear", {24'd0, r1}, 32'h0000_0000);

        // Aborted command byte: 5 bits, then cs_n high
        bus.cs_n = 1'b0;
        repeat (HALF) @(posedge clk);
        send_bits(8'h83, 5, r0);
        repeat (HALF) @(posedge clk);
        bus.cs_n = 1'b1;
        repeat (HALF) @(posedge clk);
        check("abort en/oe", {30'd0, bus.mem_en, bus.miso_oe}, 32'd0);
        check_events("abort");
        exp_q.push_back(ev_we(4'd1, 8'h3C));
        xfer("wr 81 3C", 2, 8'h81, 8'h3C, 8'h00, r0, r1, r2);

        // Reserved code
        xfer("rsvd 20", 2, 8'h20, 8'hFF, 8'h00, r0, r1, r2);
        check("rsvd miso", {24'd0, r1}, 32'h0000_0000);

        // Three-byte write and read from address 15
        exp_q.push_back(ev_we(4'd15, 8'h11));
`ifdef SPI_BURST_EN
        exp_q.push_back(ev_we(4'd0, 8'h22));
`endif
        xfer("wr 8F 11 22", 3, 8'h8F, 8'h11, 8'h22, r0, r1, r2);
        exp_q.push_back(ev_re(4'd15));
`ifdef SPI_BURST_EN
        exp_q.push_back(ev_re(4'd0));
        exp_q.push_back(ev_re(4'd1));
`endif
        xfer("rd 0F x2", 3, 8'h0F, 8'h00, 8'h00, r0, r1, r2);
        check("rd 0F byte2", {24'd0, r1}, 32'h0000_0011);
`ifdef SPI_BURST_EN
        check("rd 0F byte3", {24'd0, r2}, 32'h0000_0022);
`else
        check("rd 0F byte3", {24'd0, r2}, 32'h0000_0000);
`endif

        // Asynchronous reset in the middle of a read data byte
        exp_q.push_back(ev_re(4'd10));
        bus.cs_n = 1'b0;
        repeat (HALF) @(posedge clk);
        send_bits(8'h0A, 8, r0);
        send_bits(8'h00, 4, r1);
        check("mid rd en/oe/addr", {26'd0, bus.mem_en, bus.miso_oe, bus.mem_address},
              {26'd0, 2'b11, 4'd10});
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset outputs", out_vec(), 32'd0);
        check_events("rd before reset");
        repeat (4) @(posedge clk);
        rst_n = 1'b1;

        // cs_n stayed low through reset: no transaction without a new fall
        repeat (HALF) @(posedge clk);
        send_bits(8'h85, 8, r0);
        send_bits(8'hFF, 8, r1);
        repeat (HALF) @(posedge clk);
        check("no fresh fall outputs", out_vec(), 32'd0);
        check_events("no fresh fall");
        bus.cs_n = 1'b1;
        repeat (HALF) @(posedge clk);

        // Normal operation resumes
        exp_q.push_back(ev_we(4'd2, 8'h99));
        xfer("wr 82 99", 2, 8'h82, 8'h99, 8'h00, r0, r1, r2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
